// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy-decoded flags
// and sticky overflow/underflow error reporting.
module sync_fifo_param #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 4,
    parameter int AFULL_TH  = 3,
    parameter int AEMPTY_TH = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       err_clr,
    output logic [WIDTH-1:0]           data_out,
    output logic                       fifo_empty,
    output logic                       fifo_full,
    output logic                       almost_empty,
    output logic                       almost_full,
    output logic [$clog2(DEPTH+1)-1:0] fill_count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             pop_ok;
    logic             push_ok;

    // Every flag is a decode of the registered count, so no input reaches an output.
    assign fill_count   = count;
    assign fifo_empty   = (count == '0);
    assign fifo_full    = (count == DEPTH_C);
    assign almost_empty = (count <= AEMPTY_C);
    assign almost_full  = (count >= AFULL_C);

    // A full FIFO still takes a push when a pop frees a slot on the same edge.
    assign pop_ok  = pop & ~fifo_empty;
    assign push_ok = push & (~fifo_full | pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // A new error in the same cycle as err_clr keeps the flag set.
            overflow  <= (push & ~push_ok) | (overflow & ~err_clr);
            underflow <= (pop & ~pop_ok) | (underflow & ~err_clr);
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: three instances (default 4x4, 5x8, 7x8) driven from
// shared stimulus, each phase checked against a queue scoreboard for one instance.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] data_in;
    logic       push;
    logic       pop;
    logic       err_clr;

    logic [3:0] d0_data_out;
    logic       d0_empty, d0_full, d0_aempty, d0_afull, d0_ovf, d0_unf;
    logic [2:0] d0_count;
    logic [7:0] d1_data_out;
    logic       d1_empty, d1_full, d1_aempty, d1_afull, d1_ovf, d1_unf;
    logic [2:0] d1_count;
    logic [7:0] d2_data_out;
    logic       d2_empty, d2_full, d2_aempty, d2_afull, d2_ovf, d2_unf;
    logic [2:0] d2_count;

    int         sel;
    int         m_depth;
    int         m_afth;
    int         m_aeth;
    logic [7:0] m_mask;
    logic [7:0] sbq[$];
    logic [7:0] exp_dout;
    bit         exp_ovf;
    bit         exp_unf;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.WIDTH(4), .DEPTH(4), .AFULL_TH(3), .AEMPTY_TH(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .data_in(data_in[3:0]), .push(push), .pop(pop),
        .err_clr(err_clr), .data_out(d0_data_out), .fifo_empty(d0_empty),
        .fifo_full(d0_full), .almost_empty(d0_aempty), .almost_full(d0_afull),
        .fill_count(d0_count), .overflow(d0_ovf), .underflow(d0_unf)
    );

    sync_fifo_param #(.WIDTH(8), .DEPTH(5), .AFULL_TH(3), .AEMPTY_TH(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .push(push), .pop(pop),
        .err_clr(err_clr), .data_out(d1_data_out), .fifo_empty(d1_empty),
        .fifo_full(d1_full), .almost_empty(d1_aempty), .almost_full(d1_afull),
        .fill_count(d1_count), .overflow(d1_ovf), .underflow(d1_unf)
    );

    sync_fifo_param #(.WIDTH(8), .DEPTH(7), .AFULL_TH(6), .AEMPTY_TH(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .push(push), .pop(pop),
        .err_clr(err_clr), .data_out(d2_data_out), .fifo_empty(d2_empty),
        .fifo_full(d2_full), .almost_empty(d2_aempty), .almost_full(d2_afull),
        .fill_count(d2_count), .overflow(d2_ovf), .underflow(d2_unf)
    );

    task automatic cmp(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [31:0] o_dout;
        logic [31:0] o_cnt;
        logic        o_e, o_f, o_ae, o_af, o_ov, o_un;
        int          cnt;
        case (sel)
            0: begin
                o_dout = 32'(d0_data_out); o_cnt = 32'(d0_count);
                o_e = d0_empty; o_f = d0_full; o_ae = d0_aempty; o_af = d0_afull;
                o_ov = d0_ovf; o_un = d0_unf;
            end
            1: begin
                o_dout = 32'(d1_data_out); o_cnt = 32'(d1_count);
                o_e = d1_empty; o_f = d1_full; o_ae = d1_aempty; o_af = d1_afull;
                o_ov = d1_ovf; o_un = d1_unf;
            end
            default: begin
                o_dout = 32'(d2_data_out); o_cnt = 32'(d2_count);
                o_e = d2_empty; o_f = d2_full; o_ae = d2_aempty; o_af = d2_afull;
                o_ov = d2_ovf; o_un = d2_unf;
            end
        endcase
        cnt = sbq.size();
        cmp({tag, ":data_out"},     o_dout,      32'(exp_dout));
        cmp({tag, ":fill_count"},   o_cnt,       32'(cnt));
        cmp({tag, ":fifo_empty"},   32'(o_e),    32'(cnt == 0));
        cmp({tag, ":fifo_full"},    32'(o_f),    32'(cnt == m_depth));
        cmp({tag, ":almost_empty"}, 32'(o_ae),   32'(cnt <= m_aeth));
        cmp({tag, ":almost_full"},  32'(o_af),   32'(cnt >= m_afth));
        cmp({tag, ":overflow"},     32'(o_ov),   32'(exp_ovf));
        cmp({tag, ":underflow"},    32'(o_un),   32'(exp_unf));
    endtask

    // Drive one cycle of stimulus, predict acceptance from pre-edge model state,
    // then update the scoreboard and compare after the edge.
    task automatic applyStimulus(input bit ps, input bit pp, input logic [7:0] d,
                                 input bit clr, input string tag);
        bit pop_ok;
        bit push_ok;
        push    = ps;
        pop     = pp;
        data_in = d;
        err_clr = clr;
        pop_ok  = pp && (sbq.size() > 0);
        push_ok = ps && ((sbq.size() < m_depth) || pop_ok);
        @(posedge clk);
        #1;
        if (pop_ok) exp_dout = sbq.pop_front();
        if (push_ok) sbq.push_back(d & m_mask);
        exp_ovf = (ps && !push_ok) || (exp_ovf && !clr);
        exp_unf = (pp && !pop_ok) || (exp_unf && !clr);
        checkOutput(tag);
    endtask

    // Asynchronous reset taken between clock edges; outputs are checked before any edge.
    task automatic doReset(input int s, input int depth, input int afth, input int aeth,
                           input logic [7:0] mask);
        sel     = s;
        m_depth = depth;
        m_afth  = afth;
        m_aeth  = aeth;
        m_mask  = mask;
        #2;
        reset_n = 1'b0;
        #1;
        sbq.delete();
        exp_dout = '0;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
        checkOutput("reset");
        push    = 1'b0;
        pop     = 1'b0;
        err_clr = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b1;
        push    = 1'b0;
        pop     = 1'b0;
        err_clr = 1'b0;
        data_in = '0;

        $display("[TB] phase 0: default 4x4 directed");
        doReset(0, 4, 3, 1, 8'h0F);
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 1'b0, 8'(i), 1'b0, "fill");
        applyStimulus(1'b1, 1'b0, 8'h05, 1'b0, "push_full");
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, "err_clr_a");
        applyStimulus(1'b1, 1'b1, 8'h0A, 1'b0, "full_push_pop");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, "drain");
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, "pop_empty");
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, "err_clr_b");
        applyStimulus(1'b1, 1'b1, 8'h07, 1'b0, "empty_push_pop");
        applyStimulus(1'b1, 1'b0, 8'h08, 1'b0, "refill");
        applyStimulus(1'b1, 1'b0, 8'h09, 1'b0, "refill");
        applyStimulus(1'b1, 1'b0, 8'h0B, 1'b0, "refill");
        applyStimulus(1'b1, 1'b0, 8'h0C, 1'b1, "clr_vs_ovf");
        doReset(0, 4, 3, 1, 8'h0F);
        applyStimulus(1'b1, 1'b0, 8'h03, 1'b0, "after_reset");
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, "after_reset_pop");

        $display("[TB] phase 1: 5x8 wrap-around");
        doReset(1, 5, 3, 1, 8'hFF);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 8'(8'h30 + i), 1'b0, "wrap_fill");
        for (int i = 5; i < 12; i++) applyStimulus(1'b1, 1'b1, 8'(8'h30 + i), 1'b0, "wrap_stream");
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, "wrap_drain");

        $display("[TB] phase 2: 7x8 random");
        doReset(2, 7, 6, 2, 8'hFF);
        for (int i = 0; i < 10000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                          ($urandom_range(0, 15) == 0), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
